// File: rtl/ppu_pkg.sv
// Shared background-fetch definitions: state encoding, VRAM map, ctrl bits, line geometry.
// Latency: n/a (constants and pure combinational helpers only).
// Backpressure: n/a.
//
// Contents: fetch_state_e, VRAM base constants, ppu_ctrl bit positions,
// line geometry, and address / attribute helper functions.
package ppu_pkg;

   typedef enum logic [1:0] {
      FS_IDLE     = 2'd0,
      FS_PREFETCH = 2'd1,
      FS_RUN      = 2'd2,
      FS_DONE     = 2'd3
   } fetch_state_e;

   localparam logic [15:0] NT_BASE   = 16'h2000;
   localparam logic [9:0]  AT_OFFSET = 10'h3C0;

   localparam int CTRL1_BG_TABLE = 4;
   localparam int CTRL2_SHOW_BG  = 3;
   localparam int CTRL2_BG_LEFT  = 1;

   localparam int PIXELS_PER_LINE = 256;
   localparam int TILES_FETCHED   = 34;
   localparam int CYCLES_PER_TILE = 8;
   // Two tiles are prefetched before the first pixel leaves.
   localparam int PIXEL_START     = 2 * CYCLES_PER_TILE;

   // Name-table byte for column tx of the row containing scanline y.
   function automatic logic [15:0] nt_addr(input logic [1:0] nt,
                                           input logic [7:0] y,
                                           input logic [4:0] tx);
      return NT_BASE | {4'd0, nt, 10'd0} | {6'd0, y[7:3], 5'd0} | {11'd0, tx};
   endfunction

   // Attribute byte covering a 4x4-tile block.
   function automatic logic [15:0] at_addr(input logic [1:0] nt,
                                           input logic [7:0] y,
                                           input logic [4:0] tx);
      return NT_BASE | {6'd0, AT_OFFSET} | {4'd0, nt, 10'd0}
           | {10'd0, y[7:5], 3'd0} | {13'd0, tx[4:2]};
   endfunction

   // Pattern plane byte; hi selects the high plane (8 bytes above low).
   function automatic logic [15:0] pt_addr(input logic       pt,
                                           input logic [7:0] tile,
                                           input logic [2:0] row,
                                           input logic       hi);
      return {3'd0, pt, tile, hi, row};
   endfunction

   // Pick the 2-bit palette quadrant for this tile out of the attribute byte.
   function automatic logic [1:0] attr_pick(input logic [7:0] at,
                                            input logic       y4,
                                            input logic       tx1);
      logic [7:0] s;
      s = at >> {y4, tx1, 1'b0};
      return s[1:0];
   endfunction

endpackage

// File: rtl/ppu_bg_fetch_if.sv
// VRAM read port between the background fetcher and mem_ctrl.
// Latency: data is valid the cycle after the address is presented.
// Backpressure: none; the port accepts one read address every cycle.
//
// Signals: vram_ppu_addr (16, fetcher -> memory), vram_ppu_data (8, memory -> fetcher).
// Modports: master = fetcher, slave = memory controller.
interface ppu_bg_fetch_if;
   logic [15:0] vram_ppu_addr;
   logic [7:0]  vram_ppu_data;

   modport master (output vram_ppu_addr, input vram_ppu_data);
   modport slave  (input vram_ppu_addr, output vram_ppu_data);
endinterface

// File: rtl/ppu_bg_shifter.sv
// Background pattern/attribute shifters producing one 4-bit pixel per shift.
// Latency: pixel is combinational from the shifter heads; tile data reaches the head 8 shifts after load.
// Backpressure: none; shifts whenever shift_en is high.
//
// Ports: clk, rst (sync, active high), clear (restart line), shift_en, load,
// pat_lo/pat_hi (8, new tile planes), attr (2, new tile palette),
// pixel (4, {attr, hi, lo} of the current head bit).
module ppu_bg_shifter
   import ppu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       shift_en,
   input  logic       load,
   input  logic [7:0] pat_lo,
   input  logic [7:0] pat_hi,
   input  logic [1:0] attr,
   output logic [3:0] pixel
);

   logic [15:0] sh_lo;
   logic [15:0] sh_hi;
   logic [1:0]  attr_cur;
   logic [1:0]  attr_nxt;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         sh_lo    <= 16'd0;
         sh_hi    <= 16'd0;
         attr_cur <= 2'd0;
         attr_nxt <= 2'd0;
      end else if (load) begin
         // Load and shift on the same edge: the new tile lands in [8:1] so
         // that after the 7 following shifts its MSB sits at bit 15, exactly
         // when the last pixel of the previous tile has left.
         sh_lo    <= {sh_lo[14:8], pat_lo, 1'b0};
         sh_hi    <= {sh_hi[14:8], pat_hi, 1'b0};
         attr_cur <= attr_nxt;
         attr_nxt <= attr;
      end else if (shift_en) begin
         sh_lo <= {sh_lo[14:0], 1'b0};
         sh_hi <= {sh_hi[14:0], 1'b0};
      end
   end

   // The load edge is also the edge that emits the first pixel of the tile
   // loaded one reload earlier, whose attribute is still in attr_nxt.
   assign pixel = {(load ? attr_nxt : attr_cur), sh_hi[15], sh_lo[15]};

endmodule

// File: rtl/ppu_bg_fetch.sv
// Background tile fetcher: 34 tile fetches over VRAM, 256 palette indices per scanline.
// Latency: first pixel 16 cycles after line_start; line_done 272 cycles after line_start.
// Backpressure: none; VRAM answers every read the next cycle, pixels stream unthrottled.
//
// Ports: clk, rst (sync, active high), ppu_ctrl1/ppu_ctrl2 (latched per line),
// line_start/line_y (begin a scanline), vram (ppu_bg_fetch_if.master),
// bg_pixel (4), pixel_valid, busy, line_done. All outputs registered.
// Build option: BG_LEFT_CLIP_EN enables ppu_ctrl2[1] left-8-pixel blanking.
module ppu_bg_fetch
   import ppu_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic [7:0]     ppu_ctrl1,
   input  logic [7:0]     ppu_ctrl2,
   input  logic           line_start,
   input  logic [7:0]     line_y,
   ppu_bg_fetch_if.master vram,
   output logic [3:0]     bg_pixel,
   output logic           pixel_valid,
   output logic           busy,
   output logic           line_done
);

   localparam logic [1:0] ST_IDLE     = FS_IDLE;
   localparam logic [1:0] ST_PREFETCH = FS_PREFETCH;
   localparam logic [1:0] ST_RUN      = FS_RUN;
   localparam logic [1:0] ST_DONE     = FS_DONE;

   localparam logic [8:0] LAST_CYC  = 9'(TILES_FETCHED * CYCLES_PER_TILE - 1);
   localparam logic [8:0] RUN_CYC   = 9'(PIXEL_START);
   // Edges on which a pixel is registered for the following cycle.
   localparam logic [8:0] PIX_FIRST = 9'(PIXEL_START - 1);
   localparam logic [8:0] PIX_LAST  = 9'(PIXEL_START + PIXELS_PER_LINE - 2);

   logic [1:0]  state;
   logic [8:0]  cyc;
   logic [8:0]  nxt;
   logic [7:0]  y_l;
   logic [1:0]  nt_l;
   logic        pt_l;
   logic        show_l;
   logic [7:0]  nt_byte;
   logic [7:0]  pt_lo;
   logic [1:0]  at_bits;
   logic [15:0] addr_q;
   logic [15:0] addr_nxt;
   logic        last_cyc;
   logic        in_pix;
   logic        clip;
   logic        sh_load;
   logic [3:0]  sh_pixel;

   assign nxt      = cyc + 9'd1;
   assign last_cyc = (cyc == LAST_CYC);
   assign in_pix   = (cyc >= PIX_FIRST) && (cyc <= PIX_LAST);
   // Last data byte of every tile arrives on phase 7; it is fed straight in.
   assign sh_load  = busy && (cyc[2:0] == 3'd7);

   assign vram.vram_ppu_addr = addr_q;

`ifdef BG_LEFT_CLIP_EN
   localparam logic [8:0] CLIP_END = 9'(PIXEL_START - 1 + 8);
   logic left_l;
   logic unused_ctrl;
   assign clip        = !left_l && (cyc < CLIP_END);
   assign unused_ctrl = ^{ppu_ctrl1[7:5], ppu_ctrl1[3:2], ppu_ctrl2[7:4],
                          ppu_ctrl2[2], ppu_ctrl2[0]};
`else
   logic unused_ctrl;
   assign clip        = 1'b0;
   assign unused_ctrl = ^{ppu_ctrl1[7:5], ppu_ctrl1[3:2], ppu_ctrl2[7:4],
                          ppu_ctrl2[2:0]};
`endif

   // Address for the next cycle; odd phases simply hold the last address.
   // Tiles 32 and 33 wrap onto columns 0 and 1 through nxt[7:3].
   always_comb begin
      addr_nxt = addr_q;
      case (nxt[2:0])
         3'd0:    addr_nxt = nt_addr(nt_l, y_l, nxt[7:3]);
         3'd2:    addr_nxt = at_addr(nt_l, y_l, nxt[7:3]);
         3'd4:    addr_nxt = pt_addr(pt_l, nt_byte, y_l[2:0], 1'b0);
         3'd6:    addr_nxt = pt_addr(pt_l, nt_byte, y_l[2:0], 1'b1);
         default: addr_nxt = addr_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         cyc         <= 9'd0;
         y_l         <= 8'd0;
         nt_l        <= 2'd0;
         pt_l        <= 1'b0;
         show_l      <= 1'b0;
         nt_byte     <= 8'd0;
         pt_lo       <= 8'd0;
         at_bits     <= 2'd0;
         addr_q      <= 16'h0000;
         bg_pixel    <= 4'd0;
         pixel_valid <= 1'b0;
         busy        <= 1'b0;
         line_done   <= 1'b0;
      end else if (line_start) begin
         // Also the abort path: whatever line was running is dropped silently.
         state       <= ST_PREFETCH;
         cyc         <= 9'd0;
         y_l         <= line_y;
         nt_l        <= ppu_ctrl1[1:0];
         pt_l        <= ppu_ctrl1[CTRL1_BG_TABLE];
         show_l      <= ppu_ctrl2[CTRL2_SHOW_BG];
         addr_q      <= nt_addr(ppu_ctrl1[1:0], line_y, 5'd0);
         bg_pixel    <= 4'd0;
         pixel_valid <= 1'b0;
         busy        <= 1'b1;
         line_done   <= 1'b0;
      end else begin
         case (state)
            ST_PREFETCH, ST_RUN: begin
               case (cyc[2:0])
                  3'd1:    nt_byte <= vram.vram_ppu_data;
                  3'd3:    at_bits <= attr_pick(vram.vram_ppu_data, y_l[4], cyc[4]);
                  3'd5:    pt_lo   <= vram.vram_ppu_data;
                  default: ;
               endcase
               if (last_cyc) begin
                  state       <= ST_DONE;
                  addr_q      <= 16'h0000;
                  bg_pixel    <= 4'd0;
                  pixel_valid <= 1'b0;
                  busy        <= 1'b0;
                  line_done   <= 1'b1;
               end else begin
                  cyc         <= nxt;
                  addr_q      <= addr_nxt;
                  pixel_valid <= in_pix;
                  bg_pixel    <= (in_pix && show_l && !clip) ? sh_pixel : 4'd0;
                  if (nxt == RUN_CYC) state <= ST_RUN;
               end
            end
            ST_DONE: begin
               state     <= ST_IDLE;
               line_done <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef BG_LEFT_CLIP_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         left_l <= 1'b0;
      end else if (line_start) begin
         left_l <= ppu_ctrl2[CTRL2_BG_LEFT];
      end
   end
`endif

   ppu_bg_shifter u_shifter (
      .clk      (clk),
      .rst      (rst),
      .clear    (line_start),
      .shift_en (busy),
      .load     (sh_load),
      .pat_lo   (pt_lo),
      .pat_hi   (vram.vram_ppu_data),
      .attr     (at_bits),
      .pixel    (sh_pixel)
   );

endmodule

// File: tb/tb_ppu_bg_fetch.sv
// Scoreboard bench for ppu_bg_fetch with a 1-cycle registered VRAM model.
// Latency: expects first pixel on cycle 16 and line_done on cycle 272 after line_start.
// Backpressure: none; the monitor consumes a pixel whenever pixel_valid is high.
module tb_ppu_bg_fetch;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] ppu_ctrl1;
   logic [7:0] ppu_ctrl2;
   logic       line_start;
   logic [7:0] line_y;
   logic [3:0] bg_pixel;
   logic       pixel_valid;
   logic       busy;
   logic       line_done;

   ppu_bg_fetch_if vif ();

   ppu_bg_fetch dut (
      .clk         (clk),
      .rst         (rst),
      .ppu_ctrl1   (ppu_ctrl1),
      .ppu_ctrl2   (ppu_ctrl2),
      .line_start  (line_start),
      .line_y      (line_y),
      .vram        (vif),
      .bg_pixel    (bg_pixel),
      .pixel_valid (pixel_valid),
      .busy        (busy),
      .line_done   (line_done)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [0:65535];
   always @(posedge clk) vif.vram_ppu_data <= mem[vif.vram_ppu_addr];

   int         n_cmp = 0;
   int         n_err = 0;
   int         done_cnt = 0;
   int         extra_pix = 0;
   int         pix_seen = 0;
   logic [3:0] exp_q [$];
   int         chk_cyc [$];
   logic [15:0] chk_adr [$];
   logic [3:0] mon_e;

`ifdef BG_LEFT_CLIP_EN
   localparam bit CLIP_BUILD = 1'b1;
`else
   localparam bit CLIP_BUILD = 1'b0;
`endif

   // Tile 0 of the address test: lo = AA, hi = CC.
   logic [3:0] t0_pat [8] = '{4'h3, 4'h2, 4'h1, 4'h0, 4'h3, 4'h2, 4'h1, 4'h0};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Pixel monitor: pops one expectation per valid pixel.
   always @(negedge clk) begin
      if (line_done) done_cnt++;
      if (pixel_valid) begin
         if (exp_q.size() == 0) begin
            extra_pix++;
         end else begin
            mon_e = exp_q.pop_front();
            chk($sformatf("pixel#%0d", pix_seen), bg_pixel, mon_e);
         end
         pix_seen++;
      end else begin
         chk("pixel while not valid", bg_pixel, 4'h0);
      end
   end

   initial begin
      #1000000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   task automatic clear_mem();
      for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
   endtask

   // NT all 01, AT all E4 (quadrants 0,1,2,3), tile 1 row 0 planes F0 / 0F.
   task automatic fill_dec();
      clear_mem();
      for (int a = 16'h2000; a < 16'h23C0; a++) mem[a] = 8'h01;
      for (int a = 16'h23C0; a < 16'h2400; a++) mem[a] = 8'hE4;
      mem[16'h1010] = 8'hF0;
      mem[16'h1018] = 8'h0F;
   endtask

   // Expected pixel for the fill_dec memory (ctrl1 = 10, rows with y[2:0] = 0).
   function automatic logic [3:0] exp_dec(input int i, input logic [7:0] y, input bit clip);
      logic [1:0] attr;
      logic [1:0] pat;
      logic [8:0] iv;
      iv   = 9'(i);
      attr = {y[4], iv[4]};             // E4 quadrant k holds value k
      pat  = (iv[2:0] < 3'd4) ? 2'b01 : 2'b10;
      if (clip && i < 8) return 4'h0;
      return {attr, pat};
   endfunction

   task automatic chk_idle(input string tag);
      chk({tag, " addr"}, vif.vram_ppu_addr, 16'h0000);
      chk({tag, " bg_pixel"}, bg_pixel, 4'h0);
      chk({tag, " pixel_valid"}, pixel_valid, 1'b0);
      chk({tag, " busy"}, busy, 1'b0);
      chk({tag, " line_done"}, line_done, 1'b0);
   endtask

   task automatic add_addr(input int c, input logic [15:0] a);
      chk_cyc.push_back(c);
      chk_adr.push_back(a);
   endtask

   // Called at a negedge; returns at the negedge of cycle 0.
   task automatic start_line(input logic [7:0] c1, input logic [7:0] c2, input logic [7:0] y);
      ppu_ctrl1  = c1;
      ppu_ctrl2  = c2;
      line_y     = y;
      line_start = 1'b1;
      @(negedge clk);
      line_start = 1'b0;
      ppu_ctrl1  = 8'hFF;   // latched values must be used from now on
      ppu_ctrl2  = 8'hFF;
      line_y     = 8'hFF;
   endtask

   task automatic run_line();
      int d0;
      d0 = done_cnt;
      for (int c = 0; c <= 273; c++) begin
         if (c > 0) @(negedge clk);
         for (int k = 0; k < chk_cyc.size(); k++)
            if (chk_cyc[k] == c) chk($sformatf("addr@%0d", c), vif.vram_ppu_addr, chk_adr[k]);
         case (c)
            0:   chk("busy@0", busy, 1'b1);
            15:  chk("valid@15", pixel_valid, 1'b0);
            16:  chk("valid@16", pixel_valid, 1'b1);
            271: begin
               chk("valid@271", pixel_valid, 1'b1);
               chk("busy@271", busy, 1'b1);
               chk("done@271", line_done, 1'b0);
            end
            272: begin
               chk("busy@272", busy, 1'b0);
               chk("done@272", line_done, 1'b1);
               chk("valid@272", pixel_valid, 1'b0);
               chk("addr@272", vif.vram_ppu_addr, 16'h0000);
            end
            273: chk("done@273", line_done, 1'b0);
            default: ;
         endcase
      end
      chk("line_done count", done_cnt - d0, 1);
      chk("pixels drained", exp_q.size(), 0);
      chk_cyc.delete();
      chk_adr.delete();
   endtask

   initial begin
      int d0;
      rst        = 1'b1;
      line_start = 1'b0;
      line_y     = 8'd0;
      ppu_ctrl1  = 8'h00;
      ppu_ctrl2  = 8'h00;
      clear_mem();

      // Reset, with a line_start pulse that must be ignored.
      repeat (2) @(negedge clk);
      line_start = 1'b1;
      line_y     = 8'd3;
      @(negedge clk);
      line_start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk_idle("reset");
      repeat (3) @(negedge clk);
      chk_idle("post-reset");

      // Address sequence and plain pattern decode, attribute 0.
      mem[16'h2000] = 8'h05;
      mem[16'h0050] = 8'hAA;
      mem[16'h0058] = 8'hCC;
      mem[16'h0000] = 8'h81;
      for (int i = 0; i < 256; i++)
         exp_q.push_back(i < 8 ? t0_pat[i] : (((i % 8) == 0 || (i % 8) == 7) ? 4'h1 : 4'h0));
      add_addr(0, 16'h2000);   add_addr(2, 16'h23C0);
      add_addr(4, 16'h0050);   add_addr(6, 16'h0058);
      add_addr(8, 16'h2001);   add_addr(10, 16'h23C0);
      add_addr(12, 16'h0000);  add_addr(14, 16'h0008);
      add_addr(248, 16'h201F); add_addr(256, 16'h2000);
      add_addr(264, 16'h2001);
      start_line(8'h00, 8'h0A, 8'd0);
      run_line();

      // Attribute/pattern decode, upper pattern table, y = 0x10.
      fill_dec();
      for (int i = 0; i < 256; i++) exp_q.push_back(exp_dec(i, 8'h10, 1'b0));
      add_addr(0, 16'h2040);  add_addr(2, 16'h23C0);
      add_addr(4, 16'h1010);  add_addr(6, 16'h1018);
      add_addr(16, 16'h2042); add_addr(34, 16'h23C1);
      start_line(8'h10, 8'h0A, 8'h10);
      run_line();

      // Background off: pixels forced to zero, fetching continues.
      for (int i = 0; i < 256; i++) exp_q.push_back(4'h0);
      add_addr(4, 16'h1010);
      add_addr(200, 16'h2059);
      start_line(8'h10, 8'h00, 8'h10);
      run_line();

      // Left 8 pixels with ppu_ctrl2[1] = 0.
      for (int i = 0; i < 256; i++) exp_q.push_back(exp_dec(i, 8'h10, CLIP_BUILD));
      start_line(8'h10, 8'h08, 8'h10);
      run_line();

      // Abort at cycle 100 of a line, restart with line_y = 8.
      d0 = done_cnt;
      for (int i = 0; i < 85; i++) exp_q.push_back(exp_dec(i, 8'h00, 1'b0));
      start_line(8'h10, 8'h0A, 8'h00);
      repeat (100) @(negedge clk);
      for (int i = 0; i < 256; i++) exp_q.push_back(exp_dec(i, 8'h08, 1'b0));
      add_addr(0, 16'h2020); add_addr(2, 16'h23C0); add_addr(4, 16'h1010);
      start_line(8'h10, 8'h0A, 8'h08);
      run_line();
      chk("abort line_done total", done_cnt - d0, 1);

      // Reset in the middle of a line.
      d0 = done_cnt;
      for (int i = 0; i < 35; i++) exp_q.push_back(exp_dec(i, 8'h00, 1'b0));
      start_line(8'h10, 8'h0A, 8'h00);
      repeat (50) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_idle("mid-line reset");
      repeat (300) @(negedge clk);
      chk_idle("after mid-line reset");
      chk("reset line_done", done_cnt - d0, 0);
      chk("reset pixels drained", exp_q.size(), 0);

      chk("extra pixels", extra_pix, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
